// File: rtl/mux_pkg.sv
// Shared definitions for the registered channel selector and its arbiters.
//   MODE_FIXED / MODE_RR : encodings of the mode input
//   bufState_t           : occupancy of the one-entry output register
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // The output register is either empty or holds one word; the encoding
    // doubles as out_valid.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } bufState_t;

endpackage

// File: rtl/mux_rr_stage_rr_pick.sv
// rr_pick: rotating priority encoder.
// Grants the first asserted request found scanning from index `base`
// upwards, wrapping modulo CHANNELS.
//   req       in  CHANNELS  request vector
//   base      in  SELW      highest-priority index (must be < CHANNELS)
//   gnt_valid out 1         some request was found
//   gnt_idx   out SELW      index of the granted request (0 when none)
module rr_pick #(
    parameter  int CHANNELS = 4,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SELW-1:0]     base,
    output logic                gnt_valid,
    output logic [SELW-1:0]     gnt_idx
);

    logic [2*CHANNELS-1:0] reqTwice;
    logic [CHANNELS-1:0]   reqRot;

    function automatic logic [SELW-1:0] wrapAdd(input logic [SELW-1:0] b,
                                                input int unsigned    k);
        int unsigned s;
        s = 32'(b) + k;
        if (s >= 32'(CHANNELS)) begin
            s = s - 32'(CHANNELS);
        end
        return SELW'(s);
    endfunction

    always_comb begin
        // Rotate so that bit 0 of reqRot is request `base`; a plain
        // lowest-set-bit search then implements the wrapping scan.
        reqTwice  = {req, req} >> base;
        reqRot    = reqTwice[CHANNELS-1:0];
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (!gnt_valid && reqRot[k]) begin
                gnt_valid = 1'b1;
                gnt_idx   = wrapAdd(base, k);
            end
        end
    end

endmodule

// File: rtl/mux_rr_stage.sv
// mux_rr_stage: registered N-channel selector with valid/ready handshakes.
// Picks one input stream by fixed select or round-robin and delivers it
// through a one-entry output register.
//   clk       in  1               rising-edge clock
//   rst_n     in  1               asynchronous active-low reset
//   mode      in  1               MODE_FIXED (use sel) / MODE_RR
//   sel       in  SELW            channel index for FIXED mode
//   in_valid  in  CHANNELS        per-channel valid
//   in_data   in  CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_ready  out CHANNELS        per-channel ready (combinational)
//   out_valid out 1               output register holds a word
//   out_data  out WIDTH           registered word
//   out_chan  out SELW            channel that supplied out_data
//   out_ready in  1               consumer accepts on out_valid & out_ready
module mux_rr_stage
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    input  logic                      out_ready
);

    bufState_t           state, stateNext;
    logic [SELW-1:0]     ptr;
    logic                rrValid;
    logic [SELW-1:0]     rrIdx;
    logic                fixValid;
    logic [CHANNELS-1:0] validAtSel;
    logic                gntValid;
    logic [SELW-1:0]     gntIdx;
    logic                canLoad;
    logic [WIDTH-1:0]    selData;

    rr_pick #(.CHANNELS(CHANNELS)) uPick (
        .req       (in_valid),
        .base      (ptr),
        .gnt_valid (rrValid),
        .gnt_idx   (rrIdx)
    );

    assign out_valid = (state == BUF_FULL);
    assign canLoad   = ~out_valid | out_ready;

    // Fixed select: out-of-range sel (non-power-of-2 CHANNELS) yields no
    // grant rather than an X from indexing past the vector.
    always_comb begin
        validAtSel = in_valid >> sel;
        fixValid   = (32'(sel) < 32'(CHANNELS)) && validAtSel[0];
    end

    always_comb begin
        gntValid = 1'b0;
        gntIdx   = '0;
        if (mode == MODE_RR) begin
            gntValid = rrValid;
            gntIdx   = rrIdx;
        end else begin
            gntValid = fixValid;
            gntIdx   = sel;
        end
    end

    // in_ready is held low while reset is asserted so no producer sees a
    // handshake that the register cannot capture.
    always_comb begin
        in_ready = '0;
        selData  = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (gntIdx == SELW'(i)) begin
                in_ready[i] = rst_n & canLoad & gntValid;
                selData     = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BUF_EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (canLoad) begin
            stateNext = gntValid ? BUF_FULL : BUF_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_chan <= '0;
            ptr      <= '0;
        end else if (canLoad && gntValid) begin
            out_data <= selData;
            out_chan <= gntIdx;
            if (mode == MODE_RR) begin
                ptr <= (gntIdx == SELW'(CHANNELS - 1)) ? '0 : gntIdx + 1'b1;
            end
        end
    end

endmodule

// File: doc/mux_rr_stage.md
# mux_rr_stage

Parametrised, registered N-channel W-bit selector; the sequential successor to the team's gate-level 2:1 select cell (z = c ? b : a). It picks one of CHANNELS valid/ready input streams, either by fixed select or by round-robin, and delivers the winner through a one-entry output register with a valid/ready handshake. It sits between multiple producers and a single consumer in the lab datapath.

## Interface
- WIDTH, 8, data bits per channel (≥1)
- CHANNELS, 4, number of input channels (2..16)
- SELW, $clog2(CHANNELS), select/channel-index width (derived; not overridden)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = FIXED (use sel), 1 = RR (round-robin)
- sel  in  SELW  channel index, FIXED mode only
- in_valid  in  CHANNELS  per-channel valid
- in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  CHANNELS  per-channel ready (combinational)
- out_valid  out  1  output register holds data
- out_data  out  WIDTH  registered data
- out_chan  out  SELW  index of the channel that supplied out_data
- out_ready  in  1  consumer accepts when out_valid & out_ready

## Operation
- One-entry output register; out_valid is the only state bit of the buffer (EMPTY = 0, FULL = 1).
- can_load = ~out_valid | out_ready.
- Grant (combinational, at most one channel):
  - FIXED: grant = sel if sel < CHANNELS and in_valid[sel]; otherwise no grant. sel ≥ CHANNELS (non-power-of-2 CHANNELS) → no grant, never X.
  - RR: grant = first i with in_valid[i], scanning ptr, ptr+1, … wrapping modulo CHANNELS. No valid input → no grant.
- in_ready[i] = can_load & (grant == i). All other in_ready bits are 0.
- Transfer when grant exists and can_load: out_data ← in_data[grant], out_chan ← grant, out_valid ← 1.
- can_load with no grant: out_valid ← 0 (out_data and out_chan hold).
- out_valid & ~out_ready: register holds; all in_ready = 0.
- Round-robin pointer ptr (SELW bits): on each transfer in RR mode, ptr ← (grant+1) mod CHANNELS; wraps from CHANNELS-1 to 0. ptr does not change in FIXED mode.
- Mode and sel changes take effect in the same cycle's grant; ptr is kept across mode switches.
- Channels must hold in_valid and in_data stable until their in_ready handshake; the block does not check this.

## Timing
- Reset (async assert, sync-safe deassert): out_valid = 0, out_data = 0, out_chan = 0, ptr = 0; in_ready follows combinationally (all 1 only for the granted channel once valid).
- Latency input handshake → out_valid: 1 cycle.
- Throughput: 1 word/cycle with out_ready held high; simultaneous pop and push in the same cycle is required.
- Back-pressure: out_ready low stalls with zero loss; data presented again when out_ready rises.
- Reset mid-transfer: the held word is discarded, ptr returns to 0, no in_ready pulse in reset.
- in_ready depends combinationally on out_ready, in_valid, mode, sel and state; there is no combinational path from in_data to any output.

## Structure
- Shared package mux_pkg: MODE_FIXED = 1'b0, MODE_RR = 1'b1; clog2 helper if the tool flow lacks $clog2.
- One sub-module: rr_pick (CHANNELS parameter; inputs req vector and base ptr; outputs gnt_valid and gnt_idx); a rotating priority encoder, reused by later arbiters.
- Top holds the output register, ptr and the FIXED/RR select logic.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1 → out_valid=0, out_data=0, out_chan=0 immediately; after release, RR grants channel 0 first.
- FIXED: mode=0, sel=2, in_valid=4'b1111, data = 8'hA0..8'hA3, out_ready=1 → only in_ready[2]=1; out_data=8'hA2, out_chan=2 every cycle.
- RR fairness: mode=1, in_valid=4'b1111 continuously, out_ready=1 → out_chan sequence 0,1,2,3,0,1… one per cycle; no gaps.
- RR skip and wrap: in_valid=4'b1001 → out_chan 0,3,0,3; ptr wraps 3→0.
- Back-pressure: out_ready=0 for 3 cycles while FULL with 8'h5C → out_data stays 8'h5C, all in_ready=0; when out_ready=1 the next word loads the same cycle.
- Invalid select: CHANNELS=3, mode=0, sel=3, in_valid=3'b111 → no in_ready, out_valid drops to 0 after the pending word drains.
